rv32i_alu_arbiter: RTL
======================

RV32I_ALU_ARBITER -- requirements
Module: rv32i_alu_arbiter

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port req0_valid  input  1  requester 0 has an operation pending.
REQ-004 SHALL have port req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-005 SHALL have port req0_op  input  4  ALU opcode of requester 0 (ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101).
REQ-006 SHALL have ports req0_a, req0_b  input  32  operands of requester 0.
REQ-007 SHALL have ports req1_valid, req1_ready, req1_op, req1_a, req1_b  with the same directions, widths and meanings for requester 1.
REQ-008 SHALL have port alu_op  output  4  opcode driven to the shared ALU.
REQ-009 SHALL have ports alu_a, alu_b  output  32  operands driven to the shared ALU.
REQ-010 SHALL have port alu_result  input  32  combinational result returned by the shared ALU.
REQ-011 SHALL have port rsp_valid  output  1  response register holds a result.
REQ-012 SHALL have port rsp_ready  input  1  consumer takes the response this cycle.
REQ-013 SHALL have port rsp_id  output  1  requester index owning the response.
REQ-014 SHALL have port rsp_result  output  32  registered ALU result.

Function
REQ-015 SHALL define slot_free = !rsp_valid | rsp_ready.
REQ-016 SHALL grant at most one requester per cycle, and only when slot_free = 1.
REQ-017 SHALL, with one requester valid, grant that requester.
REQ-018 SHALL, with both requesters valid, grant the requester not granted most recently (1-bit last_grant pointer, updated only on a grant).
REQ-019 SHALL assert reqN_ready = grant to N. This is combinational from the valid inputs, rsp_valid, rsp_ready and last_grant.
REQ-020 SHALL drive alu_op/alu_a/alu_b combinationally from the granted requester. With no grant it SHALL drive 4'b0000/0/0.
REQ-021 SHALL, on a grant, load rsp_result <= alu_result, rsp_id <= granted index and rsp_valid <= 1 at the same edge. Latency is exactly 1 cycle from acceptance to rsp_valid.
REQ-022 SHALL, when rsp_valid & rsp_ready and no grant, clear rsp_valid at the next edge.
REQ-023 SHALL hold rsp_result and rsp_id stable while rsp_valid & !rsp_ready.
REQ-024 SHALL sustain one operation per cycle while rsp_ready = 1. A drain and a new acceptance in the same cycle are both legal.
REQ-025 SHALL leave a non-granted requester's operation pending; the requester holds valid, op, a and b stable until ready.
REQ-026 SHALL pass unknown opcodes to the ALU unmodified; the arbiter does not decode op.

Reset
REQ-027 SHALL, when rst = 1 at a clock edge, set rsp_valid = 0, rsp_id = 0, rsp_result = 0 and last_grant = 1, so requester 0 wins the first contention.
REQ-028 SHALL force req0_ready = req1_ready = 0 and drive ALU inputs to 0 while rst = 1.
REQ-029 SHALL discard an un-drained response and ignore any operation presented during reset.

Configuration
REQ-030 SHALL, when RV32I_ALU_ARB_FIXED_PRIO_EN is defined, use fixed priority: requester 0 always wins contention, and last_grant is not implemented.
REQ-031 SHALL, when RV32I_ALU_ARB_FIXED_PRIO_EN is undefined, use the round-robin rule of REQ-018.

Verification
REQ-032 SHALL cover: req0 only, op 0000, a=5, b=7 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12.
REQ-033 SHALL cover: req1 only, op 1000, a=3, b=5 -> next cycle rsp_id=1, rsp_result=0xFFFFFFFE.
REQ-034 SHALL cover: both valid for 4 cycles after reset, rsp_ready=1 -> grants 0,1,0,1, one response per cycle (round-robin build).
REQ-035 SHALL cover: rsp_valid=1, rsp_ready=0 for 3 cycles, both valid -> both ready = 0 and rsp_result unchanged; rsp_ready=1 -> same-cycle new grant.
REQ-036 SHALL cover: rst asserted one cycle while rsp_valid=1 -> next cycle rsp_valid=0; first contention afterwards grants requester 0.
REQ-037 SHALL cover: RV32I_ALU_ARB_FIXED_PRIO_EN defined, both valid for 3 cycles, rsp_ready=1 -> all 3 grants to requester 0, req1_ready never 1.

Source files
------------

// File: rtl/rv32i_alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the shared ALU and the
// response consumer of rv32i_alu_arbiter.
interface rv32i_alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;

    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;

    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_result,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_result,
        output rsp_ready
    );
endinterface

// File: rtl/rv32i_alu_arbiter.sv
// Two-requester arbiter for a shared RV32I ALU with a one-entry response slot.
// Define RV32I_ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module rv32i_alu_arbiter (
    input logic                   clk,
    input logic                   rst,
    rv32i_alu_arbiter_if.slave    bus
);
    logic slot_free;
    logic can_grant;
    logic grant0;
    logic grant1;

    assign slot_free = !bus.rsp_valid | bus.rsp_ready;
    assign can_grant = slot_free & !rst;

`ifdef RV32I_ALU_ARB_FIXED_PRIO_EN
    assign grant0 = can_grant & bus.req0_valid;
    assign grant1 = can_grant & bus.req1_valid & !bus.req0_valid;
`else
    logic last_grant;

    // On contention the requester that did not win last time goes first.
    assign grant0 = can_grant & bus.req0_valid & (!bus.req1_valid | last_grant);
    assign grant1 = can_grant & bus.req1_valid & (!bus.req0_valid | !last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant0 | grant1) begin
            last_grant <= grant1;
        end
    end
`endif

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        bus.alu_op = 4'b0000;
        bus.alu_a  = 32'd0;
        bus.alu_b  = 32'd0;
        unique case (1'b1)
            grant0: begin
                bus.alu_op = bus.req0_op;
                bus.alu_a  = bus.req0_a;
                bus.alu_b  = bus.req0_b;
            end
            grant1: begin
                bus.alu_op = bus.req1_op;
                bus.alu_a  = bus.req1_a;
                bus.alu_b  = bus.req1_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= 32'd0;
        end else if (grant0 | grant1) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_id     <= grant1;
            bus.rsp_result <= bus.alu_result;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid  <= 1'b0;
        end
    end
endmodule
